// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  // Fetch control states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // Byte distance between consecutive instruction words
  localparam logic [31:0] PC_INCR = 32'd4;

  // Byte address to word index shift
  localparam int WORD_SHIFT = 2;

  // One fetched instruction together with the byte address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the instruction memory read port, the redirect input and the
// decode-side valid/ready handshake.
interface instruction_fetch_unit_if;

  logic [31:0] read_address;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        fault;

  // Fetch unit side
  modport master (
    output read_address,
    output out_valid,
    output out_instruction,
    output out_pc,
    output fault,
    input  instruction,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  read_address,
    input  out_valid,
    input  out_instruction,
    input  out_pc,
    input  fault,
    output instruction,
    output redirect_valid,
    output redirect_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, instruction} entries with flush.
// The caller only pushes when there is room (or a pop frees a slot in the
// same cycle) and only pops when the queue is non-empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CW-1:0] count,
  output logic         full,
  output fetch_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  fetch_entry_t  slot_reg [DEPTH];

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointers and occupancy; flush empties the queue and wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Capture the pushed entry into the slot addressed by the write pointer
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg[gi] <= '0;
        end else if (push && !flush && (wr_ptr_reg == PW'(gi))) begin
          slot_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  assign head  = slot_reg[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the word address into a combinational
// instruction memory, queues returned words with their PC and hands them to
// decode over valid/ready. Redirects flush the queue; fetching past the end
// of memory halts with a sticky fault until the next redirect.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_WORDS  = 256,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_unit_if.master   bus
);

  localparam int          CW         = $clog2(QUEUE_DEPTH + 1);
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  fetch_state_t  state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic          fault_reg, fault_next;

  logic          push;
  logic          pop;
  logic          flush;
  logic          q_full;
  logic          q_valid;
  logic [CW-1:0] q_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  logic [31:0]   word_index;
  logic [31:0]   redirect_target;
  logic          out_of_range;

  assign word_index      = fetch_pc_reg >> WORD_SHIFT;
  assign out_of_range    = (word_index >= IMEM_LIMIT);
  assign redirect_target = bus.redirect_pc & ~(PC_INCR - 32'd1);
  assign q_valid         = (q_count != '0);
  assign pop             = q_valid && bus.out_ready;
  assign push_entry      = '{pc: fetch_pc_reg, instr: bus.instruction};

  // State, fetch PC and sticky fault registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_BOOT;
      fetch_pc_reg <= RESET_PC;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      fault_reg    <= fault_next;
    end
  end

  // Next-state logic: redirect has priority, then range check, then push
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    fault_next    = fault_reg;
    push          = 1'b0;
    flush         = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        // A redirect here only retargets the first fetch; nothing is queued yet
        state_next = ST_RUN;
        if (bus.redirect_valid) begin
          fetch_pc_next = redirect_target;
        end
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          fetch_pc_next = redirect_target;
          flush         = 1'b1;
          fault_next    = 1'b0;
        end else if (out_of_range) begin
          state_next = ST_HALT;
          fault_next = 1'b1;
        end else if (!q_full || pop) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc_reg + PC_INCR;
        end
      end
      ST_HALT: begin
        // Queue keeps draining through pops; only a redirect resumes fetching
        if (bus.redirect_valid) begin
          fetch_pc_next = redirect_target;
          flush         = 1'b1;
          fault_next    = 1'b0;
          state_next    = ST_RUN;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (q_count),
    .full      (q_full),
    .head      (head_entry)
  );

  assign bus.read_address    = word_index;
  assign bus.out_valid       = q_valid;
  assign bus.out_instruction = head_entry.instr;
  assign bus.out_pc          = head_entry.pc;
  assign bus.fault           = fault_reg;

endmodule
